// File: rtl/shift_arbiter_pkg.sv
// Shared widths and slot-state encoding for the two-requester shift arbiter.
package shift_arbiter_pkg;
    localparam int ID_W   = 1;
    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// 8-bit logical right barrel shifter, zero fill, three log-stages.
module barrel_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [AMT_W-1:0]  ctrl,
    output logic [DATA_W-1:0] out
);
    logic [DATA_W-1:0] s1, s2;

    assign s1  = ctrl[0] ? (in >> 1) : in;
    assign s2  = ctrl[1] ? (s1 >> 2) : s1;
    assign out = ctrl[2] ? (s2 >> 4) : s2;
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a single-entry response slot and saturating per-requester counters.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [AMT_W-1:0]  req_amt1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    output logic [7:0]        srv_cnt0,
    output logic [7:0]        srv_cnt1
);
    slot_state_e       state_q;
    logic [DATA_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;
    logic              ptr_q;
    logic [7:0]        cnt0_q, cnt1_q;

    logic              can_accept;
    logic [1:0]        gnt;
    logic [DATA_W-1:0] mux_data, shf_data;
    logic [AMT_W-1:0]  mux_amt;

    // rst_n gates acceptance so req_ready reads 0 while reset is held.
    assign can_accept = rst_n && ((state_q == EMPTY) || rsp_ready);
    assign gnt[0] = can_accept && req_valid[0] && (!req_valid[1] || (ptr_q == 1'b0));
    assign gnt[1] = can_accept && req_valid[1] && (!req_valid[0] || (ptr_q == 1'b1));
    assign req_ready = gnt;

    assign mux_data = gnt[1] ? req_data1 : req_data0;
    assign mux_amt  = gnt[1] ? req_amt1  : req_amt0;

    barrel_shifter u_shf (
        .in   (mux_data),
        .ctrl (mux_amt),
        .out  (shf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= RR_INIT;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            if (|gnt) begin
                state_q <= FULL;
                data_q  <= shf_data;
                id_q    <= ID_W'(gnt[1]);
                ptr_q   <= gnt[0];
            end else if (rsp_ready) begin
                state_q <= EMPTY;
            end
            if (gnt[0] && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
            if (gnt[1] && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign srv_cnt0  = cnt0_q;
    assign srv_cnt1  = cnt1_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed vector table plus hand sequences for backpressure, saturation and async reset.
module tb_shift_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_data0, req_data1;
    logic [2:0] req_amt0, req_amt1;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic [7:0] srv_cnt0, srv_cnt1;

    int total = 0;
    int bad   = 0;

    shift_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_amt0(req_amt0), .req_amt1(req_amt1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .srv_cnt0(srv_cnt0), .srv_cnt1(srv_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;
        logic [7:0] d0;
        logic [2:0] a0;
        logic [7:0] d1;
        logic [2:0] a1;
        logic       rr;
        logic [1:0] ex_rdy;
        logic       ex_v;
        logic [7:0] ex_d;
        logic       ex_id;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [2:0] a0,
                         input logic [7:0] d1, input logic [2:0] a1, input logic rr);
        req_valid = v; req_data0 = d0; req_amt0 = a0;
        req_data1 = d1; req_amt1 = a1; rsp_ready = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // vld d0 a0 d1 a1 rr | rdy v data id
        tbl[0]  = '{2'b11, 8'h80, 3'd7, 8'hF0, 3'd4, 1'b1, 2'b01, 1'b1, 8'h01, 1'b0};
        tbl[1]  = '{2'b11, 8'h80, 3'd7, 8'hF0, 3'd4, 1'b1, 2'b10, 1'b1, 8'h0F, 1'b1};
        tbl[2]  = '{2'b11, 8'h80, 3'd7, 8'hF0, 3'd4, 1'b1, 2'b01, 1'b1, 8'h01, 1'b0};
        tbl[3]  = '{2'b11, 8'h80, 3'd7, 8'hF0, 3'd4, 1'b1, 2'b10, 1'b1, 8'h0F, 1'b1};
        tbl[4]  = '{2'b01, 8'hB4, 3'd3, 8'h00, 3'd0, 1'b1, 2'b01, 1'b1, 8'h16, 1'b0};
        tbl[5]  = '{2'b10, 8'h00, 3'd0, 8'hFF, 3'd0, 1'b1, 2'b10, 1'b1, 8'hFF, 1'b1};
        tbl[6]  = '{2'b01, 8'h01, 3'd1, 8'h00, 3'd0, 1'b1, 2'b01, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{2'b10, 8'h00, 3'd0, 8'h80, 3'd7, 1'b1, 2'b10, 1'b1, 8'h01, 1'b1};
        tbl[9]  = '{2'b01, 8'h55, 3'd1, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, 8'h01, 1'b1};
        tbl[10] = '{2'b01, 8'h55, 3'd1, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, 8'h01, 1'b1};
        tbl[11] = '{2'b01, 8'h55, 3'd1, 8'h00, 3'd0, 1'b1, 2'b01, 1'b1, 8'h2A, 1'b0};

        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0);
        do_reset();

        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data",  rsp_data,  8'h00);
        chk("rst_id",    rsp_id,    1'b0);
        chk("rst_cnt0",  srv_cnt0,  8'h00);
        chk("rst_cnt1",  srv_cnt1,  8'h00);
        chk("rst_ready", req_ready, 2'b00);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].vld, tbl[i].d0, tbl[i].a0, tbl[i].d1, tbl[i].a1, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].ex_rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), rsp_valid, tbl[i].ex_v);
            if (tbl[i].ex_v) begin
                chk($sformatf("vec%0d_data", i), rsp_data, tbl[i].ex_d);
                chk($sformatf("vec%0d_id", i),   rsp_id,   tbl[i].ex_id);
            end
        end
        chk("tbl_cnt0", srv_cnt0, 8'd5);
        chk("tbl_cnt1", srv_cnt1, 8'd4);

        // backpressure: fill slot, then stall 5 cycles with a pending request
        drive(2'b10, 8'h00, 3'd0, 8'hF0, 3'd4, 1'b1);
        tick();
        chk("bp_fill", rsp_data, 8'h0F);
        drive(2'b01, 8'hB4, 3'd3, 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), req_ready, 2'b00);
            tick();
            chk($sformatf("bp%0d_valid", c), rsp_valid, 1'b1);
            chk($sformatf("bp%0d_data", c),  rsp_data,  8'h0F);
            chk($sformatf("bp%0d_id", c),    rsp_id,    1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 2'b01);
        tick();
        chk("bp_release_data", rsp_data, 8'h16);
        chk("bp_release_id",   rsp_id,   1'b0);

        // saturation: 300 back-to-back grants to requester 1
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
        do_reset();
        drive(2'b10, 8'h00, 3'd0, 8'hC3, 3'd2, 1'b1);
        for (int c = 0; c < 300; c++) tick();
        chk("sat_cnt1", srv_cnt1, 8'hFF);
        chk("sat_cnt0", srv_cnt0, 8'h00);
        chk("sat_data", rsp_data, 8'h30);

        // one grant to 0 so the pointer sits at 1, then async reset while FULL
        drive(2'b01, 8'h40, 3'd1, 8'h00, 3'd0, 1'b1);
        tick();
        chk("pre_rst_valid", rsp_valid, 1'b1);
        chk("pre_rst_data",  rsp_data,  8'h20);
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 1'b0);
        chk("arst_data",  rsp_data,  8'h00);
        chk("arst_id",    rsp_id,    1'b0);
        chk("arst_cnt0",  srv_cnt0,  8'h00);
        chk("arst_cnt1",  srv_cnt1,  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 8'hAA, 3'd1, 8'hBB, 3'd0, 1'b1);
        #1;
        chk("arst_ptr", req_ready, 2'b01);
        tick();
        chk("post_rst_data", rsp_data, 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
